// File: rtl/expand_s_pkg.sv
// expand_s_pkg: shared constants, state encoding and ML-DSA
// parameter-set defaults for the ExpandS sampler.
package expand_s_pkg;

  localparam int N              = 256;
  localparam int COEFF_WIDTH    = 24;
  localparam int COEFF_PER_WORD = 4;
  localparam int WORDS_PER_POLY = 64;

  localparam int MLDSA_K   = 8;
  localparam int MLDSA_L   = 7;
  localparam int MLDSA_ETA = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_INIT    = 3'd2,
    S_ABSORB  = 3'd3,
    S_SQUEEZE = 3'd4,
    S_SAMPLE  = 3'd5,
    S_NEXT    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/expand_s_reject.sv
// eta_reject: nibble rejection map into [-ETA, ETA].
// Ports: nibble in (4b); accept out; coeff out (24b signed).
// ETA=4 branch exists only with EXPAND_S_ETA4_EN defined.
module eta_reject
  import expand_s_pkg::*;
#(
  parameter int ETA = MLDSA_ETA
) (
  input  logic [3:0]             nibble,
  output logic                   accept,
  output logic [COEFF_WIDTH-1:0] coeff
);

`ifdef EXPAND_S_ETA4_EN
  if (ETA != 2 && ETA != 4) begin : g_eta_chk
    $error("eta_reject: ETA must be 2 or 4");
  end
`else
  if (ETA != 2) begin : g_eta_chk
    $error("eta_reject: only ETA=2 is built");
  end
`endif

  logic [3:0]        m5;
  logic signed [4:0] c2;
  logic signed [4:0] c5;

  // b mod 5 for b < 15 via two conditional subtracts
  always_comb begin
    m5 = nibble;
    if (nibble >= 4'd10)
      m5 = nibble - 4'd10;
    else if (nibble >= 4'd5)
      m5 = nibble - 4'd5;
  end

  assign c2 = 5'sd2 - $signed({1'b0, m5});

`ifdef EXPAND_S_ETA4_EN
  logic signed [4:0] c4;
  assign c4 = 5'sd4 - $signed({1'b0, nibble});
  assign accept = (ETA == 4) ? (nibble < 4'd9)
                             : (nibble < 4'd15);
  assign c5 = (ETA == 4) ? c4 : c2;
`else
  assign accept = nibble < 4'd15;
  assign c5 = c2;
`endif

  assign coeff = {{(COEFF_WIDTH-5){c5[4]}}, c5};

endmodule

// File: rtl/expand_s.sv
// expand_s: ML-DSA ExpandS sampler, drives a SHAKE256 sponge
// and writes packed s1/s2 coefficients into vector-s RAM.
// Ports: clk, rst (async high), start, rho[64];
//  RAM: we_vector_s, addr_vector_s[12], din_vector_s[96];
//  sponge: absorb_next_poly, shake_data_in, in_valid, in_last,
//  last_len, cache_rd/wr, out_ready, shake_data_out, out_valid,
//  in_ready; done pulse. Macro: EXPAND_S_ETA4_EN.
module expand_s
  import expand_s_pkg::*;
#(
  parameter int K   = MLDSA_K,
  parameter int L   = MLDSA_L,
  parameter int ETA = MLDSA_ETA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] rho,
  output logic        done,
  output logic        we_vector_s,
  output logic [11:0] addr_vector_s,
  output logic [95:0] din_vector_s,
  output logic        absorb_next_poly,
  output logic [63:0] shake_data_in,
  output logic        in_valid,
  output logic        in_last,
  output logic [6:0]  last_len,
  output logic        cache_rd,
  output logic        cache_wr,
  output logic        out_ready,
  input  logic [63:0] shake_data_out,
  input  logic        out_valid,
  input  logic        in_ready
);

  localparam int NPOLY = K + L;

  state_t            state;
  logic [7:0][63:0]  rho_buf;
  logic [2:0]        ld_cnt;
  logic [5:0]        r;
  logic [3:0]        ab_idx;
  logic [63:0]       nib_buf;
  logic [4:0]        nib_cnt;
  logic [7:0]        cnt;
  logic [71:0]       pack;
  logic              acc;
  logic [23:0]       coeff;
  logic [63:0]       ab_word;
  logic              last_poly;

  eta_reject #(.ETA(ETA)) u_rej (
    .nibble (nib_buf[3:0]),
    .accept (acc),
    .coeff  (coeff)
  );

  assign last_poly = (r == 6'(NPOLY - 1));
  // word 8 carries the 16-bit LE nonce r
  assign ab_word = (ab_idx == 4'd8) ? {58'h0, r}
                                    : rho_buf[ab_idx[2:0]];

  assign absorb_next_poly = (state == S_INIT);
  assign in_valid  = (state == S_ABSORB);
  assign in_last   = in_valid && (ab_idx == 4'd8);
  assign last_len  = in_last ? 7'd16 : 7'd0;
  assign shake_data_in = in_valid ? ab_word : 64'h0;
  assign out_ready = (state == S_SQUEEZE);
  assign done      = (state == S_DONE);
  assign cache_rd  = 1'b0;
  assign cache_wr  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rho_buf       <= '0;
      ld_cnt        <= '0;
      r             <= '0;
      ab_idx        <= '0;
      nib_buf       <= '0;
      nib_cnt       <= '0;
      cnt           <= '0;
      pack          <= '0;
      we_vector_s   <= 1'b0;
      addr_vector_s <= '0;
      din_vector_s  <= '0;
    end else begin
      we_vector_s <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            ld_cnt <= '0;
            r      <= '0;
          end
        end
        S_LOAD: begin
          rho_buf[ld_cnt] <= rho;
          ld_cnt <= ld_cnt + 3'd1;
          if (ld_cnt == 3'd7)
            state <= S_INIT;
        end
        S_INIT: begin
          ab_idx <= '0;
          state  <= S_ABSORB;
        end
        S_ABSORB: begin
          if (in_ready) begin
            if (ab_idx == 4'd8) begin
              state   <= S_SQUEEZE;
              cnt     <= '0;
              nib_cnt <= '0;
            end else begin
              ab_idx <= ab_idx + 4'd1;
            end
          end
        end
        S_SQUEEZE: begin
          if (out_valid) begin
            nib_buf <= shake_data_out;
            nib_cnt <= 5'd16;
            state   <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          nib_buf <= nib_buf >> 4;
          nib_cnt <= nib_cnt - 5'd1;
          if (acc) begin
            cnt <= cnt + 8'd1;
            unique case (cnt[1:0])
              2'd0: pack[23:0]  <= coeff;
              2'd1: pack[47:24] <= coeff;
              2'd2: pack[71:48] <= coeff;
              2'd3: begin
                we_vector_s   <= 1'b1;
                addr_vector_s <= {r, cnt[7:2]};
                din_vector_s  <= {coeff, pack};
              end
              default: ;
            endcase
          end
          // leftover nibbles are dropped once 256 are taken
          if (acc && cnt == 8'd255) begin
            state   <= S_NEXT;
            nib_cnt <= '0;
          end else if (nib_cnt == 5'd1) begin
            state <= S_SQUEEZE;
          end
        end
        S_NEXT: begin
          if (last_poly) begin
            state <= S_DONE;
          end else begin
            r     <= r + 6'd1;
            state <= S_INIT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          r     <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expand_s.sv
// tb_expand_s: directed bench for expand_s with a sponge stub
// and a software reference for the expected RAM image.
module tb_expand_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] rho = '0;
  logic        done;
  logic        we_vector_s;
  logic [11:0] addr_vector_s;
  logic [95:0] din_vector_s;
  logic        absorb_next_poly;
  logic [63:0] shake_data_in;
  logic        in_valid;
  logic        in_last;
  logic [6:0]  last_len;
  logic        cache_rd;
  logic        cache_wr;
  logic        out_ready;
  logic [63:0] shake_data_out = '0;
  logic        out_valid = 1'b0;
  logic        in_ready = 1'b0;

  always #5 clk = ~clk;

  expand_s dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rho              (rho),
    .done             (done),
    .we_vector_s      (we_vector_s),
    .addr_vector_s    (addr_vector_s),
    .din_vector_s     (din_vector_s),
    .absorb_next_poly (absorb_next_poly),
    .shake_data_in    (shake_data_in),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .last_len         (last_len),
    .cache_rd         (cache_rd),
    .cache_wr         (cache_wr),
    .out_ready        (out_ready),
    .shake_data_out   (shake_data_out),
    .out_valid        (out_valid),
    .in_ready         (in_ready)
  );

  logic [186:0] all_out;
  assign all_out = {done, we_vector_s, addr_vector_s,
                    din_vector_s, absorb_next_poly,
                    shake_data_in, in_valid, in_last,
                    last_len, cache_rd, cache_wr, out_ready};

  localparam logic [63:0] DIR_WORD = 64'hFFFF_FFFF_FFFE_54F0;
  localparam logic [95:0] DIR_DIN =
    96'hFFFFFE_000002_FFFFFE_000002;

  int checks = 0;
  int errors = 0;

  logic [95:0] ram  [0:1023];
  logic [95:0] expv [0:959];
  logic [63:0] rho_w [8];
  logic [63:0] w8 [16];
  int wr_cnt, done_cnt, anp_cnt, addr_bad, range_bad;
  int frame_bad, stall_bad, stall_seen;
  int ab_idx, stall_ctr, sq_idx;
  logic [63:0] seed, prev_data;
  bit prev_stall;
  bit dir_mode = 0;
  bit bp_mode = 0;

  function automatic logic [63:0] mix(logic [63:0] s,
                                      logic [63:0] w);
    logic [63:0] x;
    x = (s ^ w) * 64'h0000_0100_0000_01B3;
    return x ^ (x >> 29) ^ {w[31:0], w[63:32]};
  endfunction

  function automatic logic [63:0] gen(logic [63:0] s, int i);
    logic [63:0] z;
    if (dir_mode) return DIR_WORD;
    z = s + 64'h9E3779B97F4A7C15 * 64'(i + 1);
    z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
    z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
    return z ^ (z >> 31);
  endfunction

  // sponge stub, RAM model and protocol monitors
  always @(negedge clk) begin : stub
    logic signed [23:0] v;
    bit ir, ov;
    if (rst) begin
      ab_idx = 0; stall_ctr = 0; sq_idx = 0;
      prev_stall = 0; in_ready = 0; out_valid = 0;
    end else begin
      if (absorb_next_poly) begin
        anp_cnt++; ab_idx = 0; stall_ctr = 0;
        sq_idx = 0; seed = '0;
      end
      ir = !(bp_mode && in_valid && ab_idx == 4
             && stall_ctr < 5);
      if (in_valid && !ir) begin
        stall_ctr++; stall_seen++;
      end
      if (prev_stall && (!in_valid ||
          shake_data_in !== prev_data))
        stall_bad++;
      prev_stall = in_valid && !ir;
      prev_data = shake_data_in;
      in_ready = ir;
      if (in_valid && ir) begin
        if (ab_idx < 8) begin
          if (in_last || shake_data_in !== rho_w[ab_idx])
            frame_bad++;
        end else if (ab_idx == 8) begin
          if (!in_last || last_len !== 7'd16) frame_bad++;
          if (anp_cnt >= 1 && anp_cnt <= 16)
            w8[anp_cnt-1] = shake_data_in;
        end else begin
          frame_bad++;
        end
        seed = mix(seed, shake_data_in);
        ab_idx++;
      end
      ov = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_valid = ov;
      shake_data_out = gen(seed, sq_idx);
      if (out_ready && ov) sq_idx++;
      if (we_vector_s) begin
        wr_cnt++;
        if (addr_vector_s < 12'd960)
          ram[addr_vector_s] = din_vector_s;
        else
          addr_bad++;
        for (int j = 0; j < 4; j++) begin
          v = din_vector_s[24*j +: 24];
          if (v > 24'sd2 || v < -24'sd2) range_bad++;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; anp_cnt = 0; addr_bad = 0;
    range_bad = 0; frame_bad = 0; stall_bad = 0;
    stall_seen = 0;
    for (int a = 0; a < 1024; a++) ram[a] = '0;
    for (int k = 0; k < 16; k++) w8[k] = '1;
  endtask

  task automatic build_expected();
    logic [63:0] s, w;
    logic [3:0] b;
    int cnt, i, a, val;
    for (int r = 0; r < 15; r++) begin
      s = '0;
      for (int k = 0; k < 8; k++) s = mix(s, rho_w[k]);
      s = mix(s, 64'(r));
      cnt = 0; i = 0;
      while (cnt < 256) begin
        w = gen(s, i); i++;
        for (int n = 0; n < 16; n++) begin
          b = w[4*n +: 4];
          if (cnt < 256 && b < 4'd15) begin
            val = 2 - int'(b) % 5;
            a = r * 64 + cnt / 4;
            expv[a][24*(cnt%4) +: 24] = 24'(val);
            cnt++;
          end
        end
      end
    end
  endtask

  function automatic int image_mismatch();
    int m = 0;
    for (int a = 0; a < 960; a++)
      if (ram[a] !== expv[a]) m++;
    return m;
  endfunction

  task automatic start_op();
    tick(); start = 1;
    tick(); start = 0; rho = rho_w[0];
    for (int k = 1; k < 8; k++) begin
      tick(); rho = rho_w[k];
    end
    tick(); rho = '0;
  endtask

  task automatic wait_done(output bit to);
    int n = 0;
    while (done_cnt == 0 && n < 40000) begin
      tick(); n++;
    end
    to = (done_cnt == 0);
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", all_out);
    end
    rst = 0;
    repeat (3) tick();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_outs: got %h want 0", all_out);
    end
  endtask

  task automatic test_nibble_map();
    bit to;
    int mm;
    dir_mode = 1; bp_mode = 0;
    for (int k = 0; k < 8; k++) rho_w[k] = 64'(k) * 64'h1111;
    clear_mon();
    build_expected();
    start_op();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL nib_timeout: got no done want done");
    end
    checks++;
    if (ram[0] !== DIR_DIN) begin
      errors++;
      $display("FAIL nib_word0: got %h want %h", ram[0], DIR_DIN);
    end
    checks++;
    if (ram[959] !== DIR_DIN) begin
      errors++;
      $display("FAIL nib_word959: got %h want %h",
               ram[959], DIR_DIN);
    end
    mm = image_mismatch();
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL nib_image: got %0d bad want 0", mm);
    end
    checks++;
    if (wr_cnt != 960 || done_cnt != 1) begin
      errors++;
      $display("FAIL nib_counts: got wr %0d done %0d want 960 1",
               wr_cnt, done_cnt);
    end
    dir_mode = 0;
  endtask

  task automatic test_image();
    bit to;
    int mm;
    dir_mode = 0; bp_mode = 0;
    for (int k = 0; k < 8; k++) rho_w[k] = 64'h1234567890abcdef;
    clear_mon();
    build_expected();
    start_op();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL img_timeout: got no done want done");
    end
    checks++;
    if (wr_cnt != 960) begin
      errors++;
      $display("FAIL img_writes: got %0d want 960", wr_cnt);
    end
    checks++;
    if (addr_bad != 0) begin
      errors++;
      $display("FAIL img_addr: got %0d bad want 0", addr_bad);
    end
    mm = image_mismatch();
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL img_image: got %0d bad want 0", mm);
    end
    checks++;
    if (range_bad != 0) begin
      errors++;
      $display("FAIL img_range: got %0d bad want 0", range_bad);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL img_done: got %0d want 1", done_cnt);
    end
    checks++;
    if (anp_cnt != 15) begin
      errors++;
      $display("FAIL img_anp: got %0d want 15", anp_cnt);
    end
    checks++;
    if (w8[0] !== 64'h0) begin
      errors++;
      $display("FAIL nonce_r0: got %h want 0", w8[0]);
    end
    checks++;
    if (w8[14] !== 64'h000E) begin
      errors++;
      $display("FAIL nonce_r14: got %h want e", w8[14]);
    end
    checks++;
    if (frame_bad != 0) begin
      errors++;
      $display("FAIL img_frame: got %0d bad want 0", frame_bad);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int mm;
    bp_mode = 1;
    clear_mon();
    start_op();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_timeout: got no done want done");
    end
    mm = image_mismatch();
    checks++;
    if (mm != 0 || wr_cnt != 960) begin
      errors++;
      $display("FAIL bp_image: got %0d bad %0d wr want 0 960",
               mm, wr_cnt);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d bad want 0", stall_bad);
    end
    checks++;
    if (stall_seen != 75) begin
      errors++;
      $display("FAIL bp_stalls: got %0d want 75", stall_seen);
    end
    checks++;
    if (done_cnt != 1 || frame_bad != 0) begin
      errors++;
      $display("FAIL bp_done: got done %0d frame %0d want 1 0",
               done_cnt, frame_bad);
    end
    bp_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    int mm;
    clear_mon();
    start_op();
    while (!(anp_cnt == 4 && wr_cnt >= 212) && n < 40000) begin
      tick(); n++;
    end
    checks++;
    if (n >= 40000) begin
      errors++;
      $display("FAIL rmid_reach: got timeout want poly 3");
    end
    rst = 1;
    tick();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL rmid_outs: got %h want 0", all_out);
    end
    rst = 0;
    tick();
    clear_mon();
    start_op();
    wait_done(to);
    mm = image_mismatch();
    checks++;
    if (to || mm != 0 || wr_cnt != 960) begin
      errors++;
      $display("FAIL rmid_image: got %0d bad %0d wr want 0 960",
               mm, wr_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL rmid_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    int n = 0;
    int mm;
    clear_mon();
    start_op();
    while (!(wr_cnt >= 100 && !out_ready && !in_valid)
           && n < 40000) begin
      tick(); n++;
    end
    start = 1; rho = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    start = 0;
    repeat (8) tick();
    rho = '0;
    wait_done(to);
    mm = image_mismatch();
    checks++;
    if (to || mm != 0) begin
      errors++;
      $display("FAIL restart_image: got %0d bad want 0", mm);
    end
    checks++;
    if (done_cnt != 1 || wr_cnt != 960) begin
      errors++;
      $display("FAIL restart_done: got %0d %0d want 1 960",
               done_cnt, wr_cnt);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_nibble_map();
    test_image();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expand_s.md
# expand_s

ML-DSA ExpandS sampler: captures the 64-byte seed ρ′ and produces the secret vectors s1 (L polynomials) and s2 (K polynomials). Coefficients are drawn by SHAKE256 rejection sampling over 4-bit nibbles into the range [−ETA, ETA]. The block drives an external `sponge` (SHAKE256, capacity 512) and writes packed 24-bit signed coefficients into a `dp_ram_true` port used as vector-s storage. It sits in the key-generation datapath ahead of the NTT stage.

## Interface
Parameters:
- K, 8, number of s2 polynomials.
- L, 7, number of s1 polynomials.
- ETA, 2, coefficient bound; legal values are 2 and 4.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin an operation; sampled in IDLE only.
- rho  in  64  ρ′ word; 8 consecutive words, byte 0 in bits [7:0].
- done  out  1  one-cycle pulse after the final RAM write.
- we_vector_s  out  1  RAM write enable.
- addr_vector_s  out  12  RAM word address.
- din_vector_s  out  96  four coefficients; coeff j in bits [24j+:24].
- absorb_next_poly  out  1  one-cycle sponge re-init pulse before each polynomial.
- shake_data_in  out  64  absorb word.
- in_valid  out  1  absorb word valid.
- in_last  out  1  final absorb word.
- last_len  out  7  valid bits in the final word.
- cache_rd  out  1  sponge cache read; tied 0.
- cache_wr  out  1  sponge cache write; tied 0.
- out_ready  out  1  ready to accept a squeezed word.
- shake_data_out  in  64  squeezed word.
- out_valid  in  1  squeezed word valid.
- in_ready  in  1  sponge accepts an absorb word.

## Operation
- States:
  - IDLE → LOAD on start.
  - LOAD: 8 cycles capturing rho into a 512-bit buffer.
  - INIT: absorb_next_poly=1 for one cycle.
  - ABSORB: 9 words.
  - SQUEEZE/SAMPLE.
  - NEXT → INIT while r < L+K−1.
  - DONE: done pulse, then IDLE.
- Polynomial index r runs 0..L+K−1. Nonce is r as 16-bit little-endian, so s1 uses r=0..L−1 and s2 uses r=L..L+K−1.
- Absorb message is ρ′‖nonce (66 bytes):
  - Words 0–7 are the ρ′ buffer words.
  - Word 8 is {48'h0, nonce}, with in_last=1 and last_len=16.
  - A word transfers only when in_valid && in_ready.
- Squeezing:
  - A word is taken when out_valid && out_ready.
  - Nibbles are consumed low nibble first, one per cycle, 16 per word.
- Rejection rule, ETA=2: accept b<15, coeff = 2 − (b mod 5).
- Rejection rule, ETA=4: accept b<9, coeff = 4 − b.
- Each accepted coeff is sign-extended to 24 bits and packed into slot (count mod 4).
- On the 4th slot: we_vector_s=1 for one cycle, addr = r·64 + count/4, din = packed word.
- After 256 coefficients: out_ready drops, leftover squeeze output is discarded, and the flow proceeds to NEXT.
- Total writes: (L+K)·64 = 960 for the defaults, at addresses 0..959.
- start outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counters and buffer cleared.
- rho word 0 is captured on the edge after start is sampled high; words 1–7 on the following 7 edges.
- INIT follows LOAD directly. Absorb begins the cycle after absorb_next_poly.
- in_valid is held with stable data while in_ready=0.
- out_ready=1 only when the nibble buffer is empty and the polynomial is incomplete.
- Write occurs in the cycle after the 4th accepted nibble is evaluated.
- done pulses the cycle after the 960th write.
- Reset mid-operation: immediate return to IDLE, all outputs 0. RAM contents already written are left as-is.

## Configuration
- EXPAND_S_ETA4_EN:
  - Defined: the ETA=4 sampling branch is compiled in, selected by the ETA parameter.
  - Undefined: only ETA=2 exists, and ETA≠2 raises an elaboration-time $error.

## Structure
- Shared package holds:
  - N=256, COEFF_WIDTH=24, COEFF_PER_WORD=4, WORDS_PER_POLY=64.
  - The state enum typedef.
  - The ML-DSA parameter-set constants (K, L, ETA).
- One combinational sub-module, `eta_reject`: 4-bit nibble in → {accept, signed 24-bit coeff} out, parameterized by ETA.

## Test plan
- Nibble map, ETA=2: b=0→+2, 4→−2, 5→+2, 14→−2, 15→rejected (no slot advance).
- ρ′ = 64'h1234567890abcdef ×8 → exactly 960 writes at addresses 0..959, every coeff in [−2,2], all words bit-identical to a software FIPS 204 ExpandS model; done pulses once.
- Absorb framing:
  - r=0: word 8 = 64'h0, last_len=16, in_last only on word 8.
  - r=14: word 8 = 64'h000E.
  - absorb_next_poly pulses 15 times.
- Backpressure: hold in_ready=0 for 5 cycles mid-absorb, then randomly drop out_valid → data stable while stalled, identical final RAM image.
- Reset asserted during polynomial 3 → all outputs 0 next cycle; a new start reproduces the full correct 960-word image.
- start pulsed again during SAMPLE → ignored, output unchanged, a single done pulse.
